clk_ratio_detector: RTL

- Receive-side counterpart of the power-of-two clock divider: samples a divided clock, measures its period in inClk cycles, and reports the divide exponent n, where measClk = inClk / 2^n.
- Used to confirm the divider setting in the lab design, and to report it back to the control logic or a debug display.
- Reports lock only after two consecutive equal measurements. Flags non-power-of-two periods and a stopped clock.

---
 rtl/clk_ratio_detector.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/clk_ratio_detector.sv
// clk_ratio_detector: measures a divided clock's period and reports n, where measClk = inClk/2^n.
// Optional feature macro: DUTY_CHECK_EN (high-time check driving dutyErr).
module clk_ratio_detector #(
    parameter int MAX_N          = 11,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       inClk,
    input  logic       reset,
    input  logic       measClk,
    output logic [3:0] nOut,
    output logic       locked,
    output logic       update,
    output logic       badRatio,
    output logic       noClk,
    output logic       dutyErr
);
    localparam int CW   = 13;
    localparam int WARM = SYNC_STAGES + 1;
    localparam int WW   = $clog2(WARM + 1);
    localparam logic [CW-1:0] TMO  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] PMAX = CW'(1) << MAX_N;

    typedef enum logic [2:0] {
        S_SEEK,
        S_MEAS,
        S_CHECK,
        S_LOCKED,
        S_NOCLK
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_d;
    logic [WW-1:0]          r_warm;
    logic [CW-1:0]          r_cnt;
    state_t                 r_state;
    logic [3:0]             r_cand;
    logic [3:0]             r_nout;
    logic                   r_locked;
    logic                   r_update;
    logic                   r_bad;
    logic                   r_noclk;

    logic       w_sync_out;
    logic       w_warm_done;
    logic       w_rise;
    logic       w_timeout;
    logic       w_pow2;
    logic       w_valid;
    logic [3:0] w_n;
    state_t     w_state_nxt;
    logic [3:0] w_cand_nxt;
    logic [3:0] w_nout_nxt;
    logic       w_locked_nxt;
    logic       w_update_nxt;
    logic       w_bad_nxt;
    logic       w_noclk_nxt;

    assign w_sync_out  = r_sync[SYNC_STAGES-1];
    assign w_warm_done = (r_warm == WW'(WARM));
    assign w_rise      = w_warm_done & w_sync_out & ~r_sync_d;
    assign w_timeout   = (r_cnt == TMO) & ~w_rise;

    // Synchronize measClk, keep a delayed copy, and mask edges while warming up
    always_ff @(posedge inClk) begin
        if (reset) begin
            r_sync   <= '0;
            r_sync_d <= 1'b0;
            r_warm   <= '0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], measClk};
            r_sync_d <= w_sync_out;
            if (!w_warm_done) begin
                r_warm <= r_warm + WW'(1);
            end
        end
    end

    // Period counter: restarts at 1 on each rise, saturates at the timeout
    always_ff @(posedge inClk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_rise) begin
            r_cnt <= CW'(1);
        end else if (r_cnt != TMO) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign w_pow2  = ((r_cnt & (r_cnt - CW'(1))) == '0);
    assign w_valid = w_pow2 && (r_cnt >= CW'(2)) && (r_cnt <= PMAX);

    // Priority encode log2 of the measured period
    always_comb begin
        w_n = '0;
        for (int i = 1; i <= MAX_N; i++) begin
            if (r_cnt[i]) begin
                w_n = 4'(i);
            end
        end
    end

    // Next-state and output decisions for the lock tracker
    always_comb begin
        w_state_nxt  = r_state;
        w_cand_nxt   = r_cand;
        w_nout_nxt   = r_nout;
        w_locked_nxt = r_locked;
        w_update_nxt = 1'b0;
        w_bad_nxt    = 1'b0;
        w_noclk_nxt  = r_noclk;
        if (w_rise) begin
            unique case (r_state)
                S_SEEK, S_NOCLK: begin
                    w_state_nxt = S_MEAS;
                    w_noclk_nxt = 1'b0;
                end
                S_MEAS: begin
                    if (w_valid) begin
                        w_state_nxt = S_CHECK;
                        w_cand_nxt  = w_n;
                    end else begin
                        w_bad_nxt = 1'b1;
                    end
                end
                S_CHECK: begin
                    if (!w_valid) begin
                        w_state_nxt = S_MEAS;
                        w_bad_nxt   = 1'b1;
                    end else if (w_n == r_cand) begin
                        w_state_nxt  = S_LOCKED;
                        w_nout_nxt   = r_cand;
                        w_locked_nxt = 1'b1;
                        w_update_nxt = 1'b1;
                    end else begin
                        w_cand_nxt = w_n;
                    end
                end
                S_LOCKED: begin
                    if (!w_valid) begin
                        w_state_nxt  = S_MEAS;
                        w_locked_nxt = 1'b0;
                        w_bad_nxt    = 1'b1;
                    end else if (w_n != r_nout) begin
                        w_state_nxt  = S_CHECK;
                        w_cand_nxt   = w_n;
                        w_locked_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = S_SEEK;
                end
            endcase
        end else if (w_timeout && (r_state != S_NOCLK)) begin
            w_state_nxt  = S_NOCLK;
            w_nout_nxt   = '0;
            w_locked_nxt = 1'b0;
            w_noclk_nxt  = 1'b1;
        end
    end

    // State and registered outputs
    always_ff @(posedge inClk) begin
        if (reset) begin
            r_state  <= S_SEEK;
            r_cand   <= '0;
            r_nout   <= '0;
            r_locked <= 1'b0;
            r_update <= 1'b0;
            r_bad    <= 1'b0;
            r_noclk  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cand   <= w_cand_nxt;
            r_nout   <= w_nout_nxt;
            r_locked <= w_locked_nxt;
            r_update <= w_update_nxt;
            r_bad    <= w_bad_nxt;
            r_noclk  <= w_noclk_nxt;
        end
    end

    assign nOut     = r_nout;
    assign locked   = r_locked;
    assign update   = r_update;
    assign badRatio = r_bad;
    assign noClk    = r_noclk;

`ifdef DUTY_CHECK_EN
    logic [CW-1:0] r_hi;
    logic          r_duty;
    logic          w_meas_st;

    assign w_meas_st = (r_state == S_MEAS) || (r_state == S_CHECK) ||
                       (r_state == S_LOCKED);

    // High-time counter; the rise cycle itself is the first high cycle
    always_ff @(posedge inClk) begin
        if (reset) begin
            r_hi <= '0;
        end else if (w_rise) begin
            r_hi <= CW'(1);
        end else if (w_sync_out && (r_hi != TMO)) begin
            r_hi <= r_hi + CW'(1);
        end
    end

    // Advisory flag when the high time is not half the valid period
    always_ff @(posedge inClk) begin
        if (reset) begin
            r_duty <= 1'b0;
        end else begin
            r_duty <= w_rise & w_valid & w_meas_st & (r_hi != (r_cnt >> 1));
        end
    end

    assign dutyErr = r_duty;
`else
    assign dutyErr = 1'b0;
`endif

endmodule
